// File: rtl/ord_entry.sv
// Button-driven order-word entry: debounced buttons edit a hex word under a cursor,
// and a commit hands the word to the consumer through a valid/ack handshake.
module ord_entry #(
  parameter int DB_CYCLES = 16,
  parameter int DIGITS    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            btn,
  output logic [4*DIGITS-1:0]   ord,
  output logic [3:0]            cursor,
  output logic                  valid,
  input  logic                  ack
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
  localparam logic [3:0] CLAST = 4'(DIGITS - 1);

  typedef enum logic {EDIT, HOLD} state_t;

  logic [4:0]    s1, s2, db, db_d, press;
  logic [CW-1:0] cnt [5];

  state_t              state, state_n;
  logic [4*DIGITS-1:0] ord_n;
  logic [3:0]          cursor_n;
  logic                valid_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are ignored
  assign press = db & ~db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EDIT;
      ord    <= '0;
      cursor <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      ord    <= ord_n;
      cursor <= cursor_n;
      valid  <= valid_n;
    end
  end

  always_comb begin
    state_n  = state;
    ord_n    = ord;
    cursor_n = cursor;
    valid_n  = valid;
    unique case (state)
      EDIT: begin
        priority case (1'b1)
          press[4]: begin
            valid_n = 1'b1;
            state_n = HOLD;
          end
          press[0]: begin
            for (int k = 0; k < DIGITS; k++)
              if (4'(k) == cursor)
                ord_n[4*k +: 4] = ord[4*k +: 4] + 4'd1;
          end
          press[1]: begin
            for (int k = 0; k < DIGITS; k++)
              if (4'(k) == cursor)
                ord_n[4*k +: 4] = ord[4*k +: 4] - 4'd1;
          end
          press[2]: cursor_n = (cursor == CLAST) ? 4'd0 : cursor + 4'd1;
          press[3]: cursor_n = (cursor == 4'd0) ? CLAST : cursor - 4'd1;
          default: ;
        endcase
      end
      HOLD: begin
        if (ack) begin
          valid_n = 1'b0;
          state_n = EDIT;
        end
      end
      default: state_n = EDIT;
    endcase
  end

endmodule

// File: doc/ord_entry.md
# ord_entry

Button-driven entry unit that lets the operator compose the 44-bit order word (11 hex digits) that the register file consumes as `ord`, replacing a fixed order with user input. It sits between the raw `btn` pins and the CPU side, on the divided clock `clk`. It debounces and edge-detects the five buttons, edits one digit at a time under a cursor, and hands the finished word over with a valid/ack handshake.

## Interface
- `DB_CYCLES`, default 16: consecutive stable cycles required before a debounced button level changes (≥2).
- `DIGITS`, default 11: number of 4-bit digits; `ord` width = 4*DIGITS.
- `clk`  in  1  divided system clock; all state on rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `btn`  in  5  raw buttons, asynchronous: [0] digit+1, [1] digit−1, [2] cursor right, [3] cursor left, [4] commit.
- `ord`  out  4*DIGITS  current order word; digit k = `ord[4k+3:4k]`.
- `cursor`  out  4  index of the digit being edited, 0..DIGITS−1.
- `valid`  out  1  high while a committed word awaits acknowledge.
- `ack`  in  1  consumer acknowledge, sampled only while `valid`=1.

## Operation
- Per button: 2-FF synchronizer → debounce counter → debounced level `db` → press pulse = `db` & ~`db` delayed one cycle (rising edge only; releases do nothing).
- Debounce: counter increments each cycle sync ≠ `db`, clears to 0 whenever sync = `db`; when counter = DB_CYCLES−1 and still differing, `db` toggles at the next edge and counter clears. Glitches shorter than DB_CYCLES cycles never change `db`.
- FSM states: EDIT, HOLD.
- EDIT: at most one press acted on per cycle, priority commit > +1 > −1 > right > left; lower-priority simultaneous pulses are discarded, not queued.
  - +1: digit[cursor] = digit+1 mod 16 (F→0). −1: digit−1 mod 16 (0→F). Other digits untouched.
  - right: cursor+1, DIGITS−1 wraps to 0. left: cursor−1, 0 wraps to DIGITS−1.
  - commit: `valid`←1, state→HOLD; `ord` and `cursor` unchanged.
- HOLD: all button pulses discarded (debouncers keep running). `ack`=1 → `valid`←0, state→EDIT at the same edge. `ord` stays stable throughout HOLD and is retained after return to EDIT.
- `ack` in EDIT is ignored.
- Reset values: `ord`=0, `cursor`=0, `valid`=0, state EDIT, all `db`, synchronizers, counters and pulse registers 0. Reset mid-press: after release of `rst_n` a still-held button is treated as a new press once debounced.

## Timing
- `btn` bit rises at edge t and stays high: sync at t+2, `db` rises at t+2+DB_CYCLES, action (`ord`/`cursor`/`valid` change) visible after edge t+3+DB_CYCLES.
- Holding a button produces exactly one action; no auto-repeat.
- Commit→`valid` latency as above; `valid`→drop: one edge after `ack` sampled high.
- `ack` held high continuously: HOLD lasts exactly one cycle.
- A press whose pulse lands in HOLD is lost even if `ack` arrives the same cycle.
- All outputs are registered; no combinational path from `btn` or `ack` to any output.

## Test plan
- DB_CYCLES=4: reset, hold btn[0] 20 cycles → digit0=1 exactly 7 edges after press, one increment only; `ord`=44'h1, `cursor`=0.
- Glitch: btn[0] high 3 cycles then low → `ord` stays 0; then −1 press on digit 0 → digit0=F.
- Cursor wrap: left from 0 → `cursor`=10; +1 twice → `ord`=44'h200_0000_0000; right → `cursor`=0.
- Simultaneous debounced btn[0] and btn[2] → only digit+1 applied, cursor unchanged.
- Commit with `ack`=0 → `valid`=1 held 50 cycles, +1 presses ignored, `ord` stable; `ack`=1 one cycle → `valid`=0 next edge, next +1 press edits normally.
- Assert `rst_n`=0 during HOLD with `ord`≠0 → immediately `ord`=0, `cursor`=0, `valid`=0; held button acts once after reset release.
